// File: rtl/addsub_seq_if.sv
// Handshake and operand/result bundle for the digit-serial adder/subtractor.
// The master side supplies operands and consumes results. The slave side is the arithmetic unit.
interface addsub_seq_if #(
  parameter int NBIT = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [NBIT-1:0] a;
  logic [NBIT-1:0] b;
  logic            sub;
  logic            out_valid;
  logic            out_ready;
  logic [NBIT-1:0] s;
  logic            cout;
  logic            ovf;
  logic            zero;
  logic            neg;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf, zero, neg
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf, zero, neg
  );
endinterface

// File: rtl/addsub_seq.sv
// Digit-serial two's-complement adder/subtractor.
// Each operation processes DIGIT bits per cycle, LSB digit first, and takes NBIT/DIGIT cycles.
// The flag logic (cout, ovf, zero, neg) is built only when ADDSUB_SEQ_FLAGS_EN is defined.
// Without that macro, the flag outputs are tied to 0 and the ports are kept.
module addsub_seq #(
  parameter int NBIT  = 32,
  parameter int DIGIT = 8
) (
  input logic         clk,
  input logic         reset,
  addsub_seq_if.slave bus
);

  localparam int N  = NBIT / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  // Reject widths the serial datapath cannot handle.
  generate
    if (NBIT < 2 || DIGIT < 1 || (NBIT % DIGIT) != 0) begin : g_bad_params
      $error("addsub_seq: NBIT must be >= 2 and DIGIT must divide NBIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_reg, state_next;
  logic [NBIT-1:0] a_reg, b_reg, s_reg;
  logic            carry_reg;
  logic [CW-1:0]   cnt_reg;

  logic            accept;
  logic            last_digit;
  logic [DIGIT:0]  digit_sum;
  logic            carry_out;
  logic [NBIT-1:0] s_next;

  // Add one digit: low digit of a, low digit of effective b, and the running carry.
  assign digit_sum  = {1'b0, a_reg[DIGIT-1:0]} + {1'b0, b_reg[DIGIT-1:0]}
                    + {{DIGIT{1'b0}}, carry_reg};
  assign carry_out  = digit_sum[DIGIT];
  // The sum digit enters at the top of the result, and earlier digits move down.
  assign s_next     = NBIT'({digit_sum[DIGIT-1:0], s_reg} >> DIGIT);
  assign last_digit = (cnt_reg == CW'(N - 1));
  assign accept     = (state_reg == IDLE) && bus.in_valid && !reset;

  // Register the FSM state. Reset returns to IDLE and abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Compute the next state and the handshake outputs. in_ready is held low during reset.
  always_comb begin
    state_next    = state_reg;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_reg)
      IDLE: begin
        bus.in_ready = !reset;
        if (bus.in_valid) state_next = BUSY;
      end
      BUSY: begin
        if (last_digit) state_next = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Serial datapath: capture operands on accept, then shift one digit per BUSY cycle.
  // For subtraction, b is inverted and the carry is seeded with 1, so the unit computes a + ~b + 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg     <= '0;
      b_reg     <= '0;
      s_reg     <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            a_reg     <= bus.a;
            b_reg     <= bus.sub ? ~bus.b : bus.b;
            carry_reg <= bus.sub;
            cnt_reg   <= '0;
          end
        end
        BUSY: begin
          a_reg     <= a_reg >> DIGIT;
          b_reg     <= b_reg >> DIGIT;
          s_reg     <= s_next;
          carry_reg <= carry_out;
          cnt_reg   <= cnt_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.s = s_reg;

`ifdef ADDSUB_SEQ_FLAGS_EN
  logic cout_reg, ovf_reg, zero_reg, neg_reg;
  logic carry_msb_in;

  // Recover the carry into the MSB from the MSB's operand bits and its sum bit.
  assign carry_msb_in = a_reg[DIGIT-1] ^ b_reg[DIGIT-1] ^ digit_sum[DIGIT-1];

  // Latch the status flags while the final digit is being summed.
  always_ff @(posedge clk) begin
    if (reset) begin
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
      zero_reg <= 1'b0;
      neg_reg  <= 1'b0;
    end else if (state_reg == BUSY && last_digit) begin
      cout_reg <= carry_out;
      ovf_reg  <= carry_msb_in ^ carry_out;
      zero_reg <= (s_next == '0);
      neg_reg  <= s_next[NBIT-1];
    end
  end

  assign bus.cout = cout_reg;
  assign bus.ovf  = ovf_reg;
  assign bus.zero = zero_reg;
  assign bus.neg  = neg_reg;
`else
  assign bus.cout = 1'b0;
  assign bus.ovf  = 1'b0;
  assign bus.zero = 1'b0;
  assign bus.neg  = 1'b0;
`endif

endmodule

// File: doc/addsub_seq.md
# addsub_seq

Multi-cycle, digit-serial two's-complement adder/subtractor with valid/ready handshakes and status flags. It generalises the combinational ripple subtractor: width and digit size are parametrised, add or subtract is selected per operation, and carry, overflow, zero and negative flags are reported. It sits in the datapath as a low-area ALU arithmetic unit. Each operation takes NBIT/DIGIT cycles, and operands and results are registered.

## Interface
- NBIT, 32: operand/result width; must be ≥ 2.
- DIGIT, 8: bits processed per cycle; must divide NBIT exactly (elaboration error otherwise).

- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept an operation.
- a  input  NBIT  minuend / addend.
- b  input  NBIT  subtrahend / addend.
- sub  input  1  1 = a − b, 0 = a + b.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer takes result.
- s  output  NBIT  result, modulo 2^NBIT.
- cout  output  1  carry out of MSB (for sub: 1 = no borrow, a ≥ b unsigned).
- ovf  output  1  signed overflow.
- zero  output  1  s == 0.
- neg  output  1  s[NBIT−1].

## Operation
- The FSM has three states: IDLE, BUSY and DONE. N = NBIT/DIGIT.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready, capture a, the effective b (b or ~b) and the initial carry (= sub) into shift registers.
  - Clear the digit counter and go to BUSY.
- BUSY:
  - in_ready = 0.
  - Each cycle, add the low DIGIT bits of the a/b registers plus the carry register.
  - Shift the sum digit into the result register from the top; shift a/b right by DIGIT.
  - Update the carry register and increment the counter.
  - After the N-th digit, go to DONE.
- DONE:
  - out_valid = 1; s and flags stable.
  - On out_ready, go to IDLE.
  - in_ready stays 0 in DONE, so there is no accept in the same cycle as the handoff.
- Flags, computed from the final digit:
  - cout = final carry.
  - ovf = carry into MSB XOR carry out of MSB.
  - zero = (s == 0).
  - neg = s[NBIT−1].
- Inputs are ignored outside an IDLE handshake. Changing a, b or sub mid-operation has no effect.

## Timing
- Reset (synchronous, registered on the edge where reset = 1):
  - state = IDLE; s = 0; cout = ovf = zero = neg = 0; out_valid = 0; counter = 0.
  - in_ready is forced to 0 while reset is high and is 1 from the first cycle after reset deasserts.
- Latency: handshake at edge k → out_valid = 1 after edge k+N (N BUSY cycles).
  - Example: NBIT=32, DIGIT=8 gives 4 BUSY cycles.
  - DIGIT = NBIT gives 1 BUSY cycle.
- Throughput: one operation per N+2 cycles at best (IDLE, N×BUSY, DONE).
- Backpressure: out_valid, s and flags hold indefinitely in DONE until out_ready = 1.
- out_ready while out_valid = 0 is ignored.
- Reset mid-operation (BUSY or DONE): the operation is abandoned, no out_valid is produced, and all reset values apply on the next cycle.
- Simultaneous reset with in_valid: reset wins and nothing is captured.
- Wrap-around: results are modulo 2^NBIT; overflow is reported only through the flags.

## Configuration
- ADDSUB_SEQ_FLAGS_EN defined: the cout, ovf, zero and neg flag logic and registers are built as above.
- Macro undefined:
  - The flag registers are not synthesised; cout, ovf, zero and neg are tied to 0.
  - s, timing and handshakes are unchanged, and the ports remain for interface compatibility.

## Test plan
All scenarios at NBIT=32, DIGIT=8, flags enabled, unless stated.
- Subtract, no borrow: a=5, b=3, sub=1.
  - s=0x00000002; cout=1, ovf=0, zero=0, neg=0.
  - out_valid exactly 4 cycles after accept.
- Subtract with borrow: a=3, b=5, sub=1.
  - s=0xFFFFFFFE; cout=0, neg=1, ovf=0.
- Add with signed overflow: a=0x7FFFFFFF, b=1, sub=0.
  - s=0x80000000; ovf=1, neg=1, cout=0.
- Add with unsigned wrap: a=0xFFFFFFFF, b=1, sub=0.
  - s=0; cout=1, zero=1, ovf=0.
- Backpressure and mid-operation reset:
  - Hold out_ready=0 for 10 cycles: out_valid and s stay stable and in_ready stays 0.
  - Separately, assert reset in the 2nd BUSY cycle: out_valid never rises, all outputs read 0, and in_ready=1 after reset deasserts.
- Parameter sweep and macro: NBIT=8, DIGIT=1, a=0x80, b=0x01, sub=1.
  - s=0x7F, ovf=1, cout=1, latency 8.
  - Repeat with ADDSUB_SEQ_FLAGS_EN undefined: s=0x7F and all flags read 0.
